// File: rtl/nubus_pkg.sv
// Shared NuBus slave definitions: FSM states, TM status codes, slot prefix,
// access-size encodings and counter width.
package nubus_pkg;

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WDATA  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

    // Active-high {tm1, tm0} status codes; inverted onto TM* by the responder
    localparam logic [1:0] TM_COMPLETE = 2'b00;
    localparam logic [1:0] TM_ERROR    = 2'b01;
    localparam logic [1:0] TM_TIMEOUT  = 2'b10;
    localparam logic [1:0] TM_TRYAGAIN = 2'b11;

    localparam logic [3:0] SLOT_PREFIX = 4'hF;

    typedef enum logic [1:0] {
        SZ_WORD  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_BYTE  = 2'd2,
        SZ_BLOCK = 2'd3
    } size_t;

endpackage

// File: rtl/nubus_slave_decode.sv
// Combinational address match and mode/lane decode for the NuBus slave.
// Ports: idn (slot ID, active-low), adn_hi/adn_lo (AD*[31:24] and AD*[1:0]),
//        tm0n/tm1n (TM*), hit/write/block/wstrb (decoded, active-high).
module nubus_slave_decode
    import nubus_pkg::*;
#(
    parameter bit SUPER_EN = 1'b1
) (
    input  logic [3:0] idn,
    input  logic [7:0] adn_hi,
    input  logic [1:0] adn_lo,
    input  logic       tm0n,
    input  logic       tm1n,
    output logic       hit,
    output logic       write,
    output logic       block,
    output logic [3:0] wstrb
);

    logic [7:0] addr_hi;
    logic [3:0] id;
    logic [1:0] a;
    size_t      size;

    always_comb begin
        addr_hi = ~adn_hi;
        id      = ~idn;
        a       = ~adn_lo;
        hit     = (addr_hi == {SLOT_PREFIX, id}) || (SUPER_EN && (addr_hi[7:4] == id));
        write   = ~tm1n;

        // tm0 active selects a byte; otherwise the low address bits pick the size
        size = SZ_WORD;
        if (!tm0n) begin
            size = SZ_BYTE;
        end else begin
            case (a)
                2'b00:   size = SZ_WORD;
                2'b01:   size = SZ_BLOCK;
                default: size = SZ_HALF;
            endcase
        end
        block = (size == SZ_BLOCK);

        case (size)
            SZ_BYTE: wstrb = 4'(4'b0001 << a);
            SZ_HALF: wstrb = a[0] ? 4'b1100 : 4'b0011;
            SZ_WORD: wstrb = 4'b1111;
            default: wstrb = 4'b0000;
        endcase
        if (!write) begin
            wstrb = 4'b1111;
        end
    end

endmodule

// File: rtl/nubus_slave_responder.sv
// NuBus slave responder: decodes slot/superslot accesses, performs one local
// memory access per transaction and answers with a single-cycle ACK* + TM*.
// Ports: nub_* bus side (active-low, *_o drive values, *oen_o enables),
//        slv_ackcyn (low in ACK cycle), mem_* local memory request/response.
module nubus_slave_responder
    import nubus_pkg::*;
#(
    parameter bit          SUPER_EN = 1'b1,
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic        nub_clkn,
    input  logic        nub_reset,
    input  logic [3:0]  nub_idn,
    input  logic        nub_startn,
    input  logic        nub_ackn,
    input  logic        nub_tm0n,
    input  logic        nub_tm1n,
    input  logic [31:0] nub_adn,
    output logic        nub_ackn_o,
    output logic        nub_tm0n_o,
    output logic        nub_tm1n_o,
    output logic        nub_tmoen_o,
    output logic [31:0] nub_adn_o,
    output logic        nub_adoen_o,
    output logic        slv_ackcyn,
    output logic        mem_valid_o,
    output logic        mem_write_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_ready_i,
    input  logic        mem_err_i,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             blk_q, blk_d;

    logic             dec_hit, dec_write, dec_block;
    logic [3:0]       dec_wstrb;

    logic             ackn_d, tm0n_d, tm1n_d, tmoen_d, adoen_d, slv_d;
    logic [31:0]      adn_d;
    logic             valid_d, write_d;
    logic [31:0]      addr_d, wdata_d;
    logic [3:0]       wstrb_d;

    logic             ack_go, drive_ad;
    logic [1:0]       status;

    nubus_slave_decode #(.SUPER_EN(SUPER_EN)) u_decode (
        .idn    (nub_idn),
        .adn_hi (nub_adn[31:24]),
        .adn_lo (nub_adn[1:0]),
        .tm0n   (nub_tm0n),
        .tm1n   (nub_tm1n),
        .hit    (dec_hit),
        .write  (dec_write),
        .block  (dec_block),
        .wstrb  (dec_wstrb)
    );

    // State register
    always_ff @(posedge nub_clkn) begin
        if (nub_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next registered outputs; bus drivers default to released
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        blk_d    = blk_q;
        valid_d  = 1'b0;
        write_d  = mem_write_o;
        addr_d   = mem_addr_o;
        wdata_d  = mem_wdata_o;
        wstrb_d  = mem_wstrb_o;
        ackn_d   = 1'b1;
        tm0n_d   = 1'b1;
        tm1n_d   = 1'b1;
        tmoen_d  = 1'b1;
        adn_d    = '1;
        adoen_d  = 1'b1;
        slv_d    = 1'b1;
        ack_go   = 1'b0;
        drive_ad = 1'b0;
        status   = TM_COMPLETE;

        case (state_q)
            ST_IDLE: begin
                // ACK* low alongside START* is an attention cycle, not a start
                if (!nub_startn && nub_ackn && dec_hit) begin
                    write_d = dec_write;
                    addr_d  = {~nub_adn[31:2], 2'b00};
                    wstrb_d = dec_wstrb;
                    blk_d   = dec_block;
                    cnt_d   = '0;
                    if (dec_write) begin
                        state_d = ST_WDATA;
                    end else if (dec_block) begin
                        ack_go = 1'b1;
                        status = TM_ERROR;
                    end else begin
                        state_d = ST_ACCESS;
                        valid_d = 1'b1;
                    end
                end
            end
            ST_WDATA: begin
                wdata_d = ~nub_adn;
                if (blk_q) begin
                    ack_go = 1'b1;
                    status = TM_ERROR;
                end else begin
                    state_d = ST_ACCESS;
                    valid_d = 1'b1;
                end
            end
            ST_ACCESS: begin
                // Ready takes priority over expiry in the same cycle
                if (mem_ready_i) begin
                    ack_go   = 1'b1;
                    status   = {1'b0, mem_err_i};
                    drive_ad = !mem_write_o && !mem_err_i;
                end else if (cnt_q == CNT_LAST) begin
                    ack_go = 1'b1;
                    status = TM_TRYAGAIN;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    valid_d = 1'b1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (ack_go) begin
            state_d = ST_ACK;
            ackn_d  = 1'b0;
            tmoen_d = 1'b0;
            tm1n_d  = ~status[1];
            tm0n_d  = ~status[0];
            slv_d   = 1'b0;
            if (drive_ad) begin
                adoen_d = 1'b0;
                adn_d   = ~mem_rdata_i;
            end
        end
    end

    // Counter, latched mode and output registers
    always_ff @(posedge nub_clkn) begin
        if (nub_reset) begin
            cnt_q       <= '0;
            blk_q       <= 1'b0;
            nub_ackn_o  <= 1'b1;
            nub_tm0n_o  <= 1'b1;
            nub_tm1n_o  <= 1'b1;
            nub_tmoen_o <= 1'b1;
            nub_adn_o   <= '1;
            nub_adoen_o <= 1'b1;
            slv_ackcyn  <= 1'b1;
            mem_valid_o <= 1'b0;
            mem_write_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wstrb_o <= '0;
        end else begin
            cnt_q       <= cnt_d;
            blk_q       <= blk_d;
            nub_ackn_o  <= ackn_d;
            nub_tm0n_o  <= tm0n_d;
            nub_tm1n_o  <= tm1n_d;
            nub_tmoen_o <= tmoen_d;
            nub_adn_o   <= adn_d;
            nub_adoen_o <= adoen_d;
            slv_ackcyn  <= slv_d;
            mem_valid_o <= valid_d;
            mem_write_o <= write_d;
            mem_addr_o  <= addr_d;
            mem_wdata_o <= wdata_d;
            mem_wstrb_o <= wstrb_d;
        end
    end

endmodule

// File: tb/tb_nubus_slave_responder.sv
// Self-checking bench for nubus_slave_responder: a table of directed bus
// transactions plus hand-written reset, attention and abort sequences.
module tb_nubus_slave_responder;

    localparam int WIN = 10;

    logic        nub_clkn = 1'b0;
    logic        nub_reset;
    logic [3:0]  nub_idn;
    logic        nub_startn, nub_ackn, nub_tm0n, nub_tm1n;
    logic [31:0] nub_adn;
    logic        mem_ready_i, mem_err_i;
    logic [31:0] mem_rdata_i;

    logic        nub_ackn_o, nub_tm0n_o, nub_tm1n_o, nub_tmoen_o, nub_adoen_o, slv_ackcyn;
    logic [31:0] nub_adn_o;
    logic        mem_valid_o, mem_write_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_wstrb_o;

    logic        ns_ackn_o, ns_tm0n_o, ns_tm1n_o, ns_tmoen_o, ns_adoen_o, ns_slv;
    logic [31:0] ns_adn_o;
    logic        ns_valid, ns_write;
    logic [31:0] ns_addr, ns_wdata;
    logic [3:0]  ns_wstrb;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 nub_clkn = ~nub_clkn;

    nubus_slave_responder #(.SUPER_EN(1'b1), .MAX_WAIT(4)) dut (
        .nub_clkn(nub_clkn), .nub_reset(nub_reset), .nub_idn(nub_idn),
        .nub_startn(nub_startn), .nub_ackn(nub_ackn), .nub_tm0n(nub_tm0n),
        .nub_tm1n(nub_tm1n), .nub_adn(nub_adn),
        .nub_ackn_o(nub_ackn_o), .nub_tm0n_o(nub_tm0n_o), .nub_tm1n_o(nub_tm1n_o),
        .nub_tmoen_o(nub_tmoen_o), .nub_adn_o(nub_adn_o), .nub_adoen_o(nub_adoen_o),
        .slv_ackcyn(slv_ackcyn), .mem_valid_o(mem_valid_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_ready_i(mem_ready_i), .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i)
    );

    nubus_slave_responder #(.SUPER_EN(1'b0), .MAX_WAIT(4)) dut_ns (
        .nub_clkn(nub_clkn), .nub_reset(nub_reset), .nub_idn(nub_idn),
        .nub_startn(nub_startn), .nub_ackn(nub_ackn), .nub_tm0n(nub_tm0n),
        .nub_tm1n(nub_tm1n), .nub_adn(nub_adn),
        .nub_ackn_o(ns_ackn_o), .nub_tm0n_o(ns_tm0n_o), .nub_tm1n_o(ns_tm1n_o),
        .nub_tmoen_o(ns_tmoen_o), .nub_adn_o(ns_adn_o), .nub_adoen_o(ns_adoen_o),
        .slv_ackcyn(ns_slv), .mem_valid_o(ns_valid), .mem_write_o(ns_write),
        .mem_addr_o(ns_addr), .mem_wdata_o(ns_wdata), .mem_wstrb_o(ns_wstrb),
        .mem_ready_i(mem_ready_i), .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i)
    );

    typedef struct {
        logic [31:0] addr;
        logic        tm1;
        logic        tm0;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;      // valid cycles before ready is given
        logic        err;
        int          exp_ack;    // cycle index of ACK after START edge, 0 = none
        int          exp_valid;  // number of mem_valid_o cycles
        logic [1:0]  exp_tmn;    // {TM1*, TM0*} during ACK
        logic        exp_ad;     // AD* driven during ACK
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_addr;
        logic        exp_ns;     // SUPER_EN=0 instance also acks
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        nub_startn  = 1'b1;
        nub_ackn    = 1'b1;
        nub_tm0n    = 1'b1;
        nub_tm1n    = 1'b1;
        nub_adn     = '1;
        mem_ready_i = 1'b0;
        mem_err_i   = 1'b0;
        mem_rdata_i = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(mem_valid_o), 32'd0);
        check({tag, "_drv"}, 32'({nub_ackn_o, nub_tm1n_o, nub_tm0n_o, nub_tmoen_o,
                                  nub_adoen_o, slv_ackcyn}), 32'h3F);
        check({tag, "_adn"}, nub_adn_o, 32'hFFFF_FFFF);
        check({tag, "_mem"}, 32'({mem_write_o, mem_wstrb_o}), 32'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int vcnt = 0;
        int ack_at = 0;
        int ack_cnt = 0;
        int nsack = 0;
        logic bad_rel = 1'b0;
        logic [1:0]  got_tmn = 2'b11;
        logic        got_adoen = 1'b1;
        logic        got_slv = 1'b1;
        logic [31:0] got_adn = '1;
        logic [31:0] got_addr = '0;
        logic [31:0] got_wdata = '0;
        logic [3:0]  got_wstrb = '0;
        logic        got_write = 1'b0;
        string       t;
        t = $sformatf("v%0d", idx);

        @(negedge nub_clkn);
        nub_startn = 1'b0;
        nub_adn    = ~v.addr;
        nub_tm1n   = ~v.tm1;
        nub_tm0n   = ~v.tm0;
        for (int n = 1; n <= WIN; n++) begin
            @(negedge nub_clkn);
            if (mem_valid_o) begin
                vcnt++;
                if (vcnt == 1) begin
                    got_addr  = mem_addr_o;
                    got_wdata = mem_wdata_o;
                    got_wstrb = mem_wstrb_o;
                    got_write = mem_write_o;
                end
            end
            if (!nub_ackn_o) begin
                ack_cnt++;
                if (ack_at == 0) begin
                    ack_at    = n;
                    got_tmn   = {nub_tm1n_o, nub_tm0n_o};
                    got_adoen = nub_adoen_o;
                    got_adn   = nub_adn_o;
                    got_slv   = slv_ackcyn | nub_tmoen_o;
                end
            end else if (!nub_tmoen_o || !nub_adoen_o || !slv_ackcyn || !nub_tm0n_o || !nub_tm1n_o) begin
                bad_rel = 1'b1;
            end
            if (!ns_ackn_o) nsack++;
            // Next-cycle bus/memory inputs
            nub_startn  = 1'b1;
            nub_tm1n    = 1'b1;
            nub_tm0n    = 1'b1;
            nub_adn     = (n == 1 && v.tm1) ? ~v.wdata : 32'hFFFF_FFFF;
            mem_ready_i = mem_valid_o && (vcnt > v.delay);
            mem_err_i   = v.err;
            mem_rdata_i = v.rdata;
        end
        mem_ready_i = 1'b0;
        mem_err_i   = 1'b0;

        check({t, "_ack_cycle"}, 32'(ack_at), 32'(v.exp_ack));
        check({t, "_ack_width"}, 32'(ack_cnt), (v.exp_ack != 0) ? 32'd1 : 32'd0);
        check({t, "_valid_cycles"}, 32'(vcnt), 32'(v.exp_valid));
        check({t, "_released"}, 32'(bad_rel), 32'd0);
        check({t, "_ns_ack"}, 32'(nsack), 32'(v.exp_ns && (v.exp_ack != 0)));
        if (v.exp_ack != 0) begin
            check({t, "_tm"}, 32'(got_tmn), 32'(v.exp_tmn));
            check({t, "_slv_tmoe"}, 32'(got_slv), 32'd0);
            check({t, "_adoen"}, 32'(got_adoen), 32'(!v.exp_ad));
            if (v.exp_ad) check({t, "_adn"}, got_adn, ~v.rdata);
        end
        if (v.exp_valid != 0) begin
            check({t, "_addr"}, got_addr, v.exp_addr);
            check({t, "_wstrb"}, 32'(got_wstrb), 32'(v.exp_wstrb));
            check({t, "_write"}, 32'(got_write), 32'(v.tm1));
            if (v.tm1) check({t, "_wdata"}, got_wdata, v.wdata);
        end
    endtask

    initial begin
        int vc;
        int ac;

        //            addr          tm1   tm0   wdata         rdata         dly err  ack val tmn    ad    wstrb    exp_addr      ns
        vecs[0]  = '{32'hF9000100, 1'b0, 1'b0, 32'h0,        32'hDEADBEEF, 0,  1'b0, 2, 1, 2'b11, 1'b1, 4'b1111, 32'hF9000100, 1'b1};
        vecs[1]  = '{32'hF9000003, 1'b1, 1'b1, 32'h000000A5, 32'h0,        0,  1'b0, 3, 1, 2'b11, 1'b0, 4'b1000, 32'hF9000000, 1'b1};
        vecs[2]  = '{32'hF9000200, 1'b0, 1'b0, 32'h0,        32'h11111111, 99, 1'b0, 5, 4, 2'b00, 1'b0, 4'b1111, 32'hF9000200, 1'b1};
        vecs[3]  = '{32'hF9000010, 1'b0, 1'b0, 32'h0,        32'hCAFEF00D, 1,  1'b1, 3, 2, 2'b10, 1'b0, 4'b1111, 32'hF9000010, 1'b1};
        vecs[4]  = '{32'hF9000001, 1'b0, 1'b0, 32'h0,        32'h0,        0,  1'b0, 1, 0, 2'b10, 1'b0, 4'b0000, 32'h0,        1'b1};
        vecs[5]  = '{32'hF9000005, 1'b1, 1'b0, 32'h0,        32'h0,        0,  1'b0, 2, 0, 2'b10, 1'b0, 4'b0000, 32'h0,        1'b1};
        vecs[6]  = '{32'hF9000002, 1'b1, 1'b0, 32'h00001234, 32'h0,        2,  1'b0, 5, 3, 2'b11, 1'b0, 4'b0011, 32'hF9000000, 1'b1};
        vecs[7]  = '{32'hF9000003, 1'b1, 1'b0, 32'hABCD0000, 32'h0,        0,  1'b0, 3, 1, 2'b11, 1'b0, 4'b1100, 32'hF9000000, 1'b1};
        vecs[8]  = '{32'hF9000102, 1'b0, 1'b1, 32'h0,        32'h0BADF00D, 0,  1'b0, 2, 1, 2'b11, 1'b1, 4'b1111, 32'hF9000100, 1'b1};
        vecs[9]  = '{32'hF9000300, 1'b0, 1'b0, 32'h0,        32'h600DCAFE, 3,  1'b0, 5, 4, 2'b11, 1'b1, 4'b1111, 32'hF9000300, 1'b1};
        vecs[10] = '{32'hF9000404, 1'b1, 1'b0, 32'h55AA55AA, 32'h0,        99, 1'b0, 6, 4, 2'b00, 1'b0, 4'b1111, 32'hF9000404, 1'b1};
        vecs[11] = '{32'hFA000000, 1'b0, 1'b0, 32'h0,        32'h0,        0,  1'b0, 0, 0, 2'b11, 1'b0, 4'b0000, 32'h0,        1'b0};
        vecs[12] = '{32'h90000040, 1'b0, 1'b0, 32'h0,        32'h12345678, 0,  1'b0, 2, 1, 2'b11, 1'b1, 4'b1111, 32'h90000040, 1'b0};

        nub_idn   = 4'h6;   // slot ID 9
        nub_reset = 1'b1;
        idle_bus();
        repeat (3) @(negedge nub_clkn);
        check_reset_outputs("reset");
        nub_reset = 1'b0;
        @(negedge nub_clkn);

        for (int i = 0; i < 13; i++) begin
            run_vec(i, vecs[i]);
        end

        // Attention cycle: START* and ACK* both low on a matching address
        @(negedge nub_clkn);
        nub_startn = 1'b0;
        nub_ackn   = 1'b0;
        nub_adn    = ~32'hF9000100;
        vc = 0;
        ac = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge nub_clkn);
            idle_bus();
            if (mem_valid_o) vc++;
            if (!nub_ackn_o || !nub_tmoen_o || !nub_adoen_o) ac++;
        end
        check("attn_valid", 32'(vc), 32'd0);
        check("attn_drive", 32'(ac), 32'd0);

        // Reset while in ACCESS
        @(negedge nub_clkn);
        nub_startn = 1'b0;
        nub_adn    = ~32'hF9000100;
        nub_tm1n   = 1'b1;
        nub_tm0n   = 1'b1;
        @(negedge nub_clkn);
        idle_bus();
        check("abort_pre_valid", 32'(mem_valid_o), 32'd1);
        @(negedge nub_clkn);
        nub_reset = 1'b1;
        @(negedge nub_clkn);
        check_reset_outputs("abort");
        nub_reset = 1'b0;
        ac = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge nub_clkn);
            if (!nub_ackn_o || mem_valid_o) ac++;
        end
        check("abort_no_ack", 32'(ac), 32'd0);
        run_vec(100, vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nubus_slave_responder.md
# nubus_slave_responder

NuBus slave-side transaction responder for a card. Samples START*/TM*/AD* from the bus, decodes card slot or superslot address space, runs one local memory access per transaction, then drives a single-cycle ACK* with a TM status code and, for reads, the read data on AD*. It is the responder counterpart of the card's master-side bus driver. Its `slv_ackcyn` output feeds that driver's slave-acknowledge input.

## Interface
Parameters:
- `SUPER_EN`, 1: also respond to superslot space (addr[31:28] == slot ID).
- `MAX_WAIT`, 64: maximum ACCESS cycles before answering try-again-later (2..255).

Ports:
- `nub_clkn`  in  1: card clock. All state updates occur on its rising edge.
- `nub_reset`  in  1: synchronous, active-high reset.
- `nub_idn`  in  4: slot ID, active-low.
- `nub_startn`  in  1: START*, active-low.
- `nub_ackn`  in  1: ACK* as seen on bus, active-low.
- `nub_tm0n`, `nub_tm1n`  in  1 each: TM* as seen on bus.
- `nub_adn`  in  32: AD* as seen on bus, active-low.
- `nub_ackn_o`, `nub_tm0n_o`, `nub_tm1n_o`  out  1 each: slave ACK*/TM* drive values.
- `nub_tmoen_o`  out  1: active-low enable for ACK*/TM* drivers.
- `nub_adn_o`  out  32: AD* drive value.
- `nub_adoen_o`  out  1: active-low enable for the AD* drivers.
- `slv_ackcyn`  out  1: low during the ACK cycle.
- `mem_valid_o`  out  1: local access request.
- `mem_write_o`  out  1: 1 = write.
- `mem_addr_o`  out  32: byte address, with [1:0] forced to 00.
- `mem_wdata_o`  out  32: write data.
- `mem_wstrb_o`  out  4: byte lane enables.
- `mem_ready_i`  in  1: single-cycle completion.
- `mem_err_i`  in  1: error, qualified by `mem_ready_i`.
- `mem_rdata_i`  in  32: read data, qualified by `mem_ready_i`.

## Operation
Bus values are inverted internally: addr = ~nub_adn, tm1 = ~nub_tm1n, tm0 = ~nub_tm0n, a = addr[1:0].

Address match:
- Slot space: addr[31:24] == {4'hF, ~nub_idn}.
- Superslot space: addr[31:28] == ~nub_idn, only when SUPER_EN=1.

Transaction start:
- A start is START*=0 and ACK*=1 in IDLE with an address match.
- START*=0 with ACK*=0 is an attention cycle and is ignored.

Mode decode, latched at start:
- tm1=1 selects write; tm1=0 selects read.
- tm0=1 is a byte access: wstrb = 1<<a.
- tm0=0 decodes on a:
  - a=00: word, wstrb 1111.
  - a=10: half, wstrb 0011.
  - a=11: half, wstrb 1100.
  - a=01: block, unsupported.
- Reads assert all four strobes regardless of size.

Status on ACK (tm1,tm0 active-high, inverted onto the bus):
- 00: complete.
- 01: error (mem_err_i, or block request).
- 10: reserved, never generated.
- 11: try-again-later (MAX_WAIT expired).

States:
- IDLE:
  - Read start goes to ACCESS.
  - Write start goes to WDATA.
  - Block start goes to WDATA if a write, otherwise directly to ACK with status 01.
- WDATA: capture ~nub_adn as write data. Go to ACCESS, or to ACK (status 01) for a block request.
- ACCESS:
  - mem_valid_o=1 with stable addr/wdata/wstrb/write. The wait counter increments each cycle.
  - mem_ready_i goes to ACK with status {0, mem_err_i} and latches rdata.
  - Counter at MAX_WAIT-1 without ready goes to ACK with status 11.
  - If ready and expiry occur in the same cycle, ready wins.
- ACK:
  - nub_tmoen_o=0, nub_ackn_o=0, TM per status, slv_ackcyn=0.
  - Reads with status 00 also drive nub_adoen_o=0 and nub_adn_o = ~rdata.
  - Always return to IDLE.
  - START*=0 seen in ACK is not a start.

## Timing
Reset values:
- All enables high (released); nub_ackn_o, nub_tm0n_o, nub_tm1n_o = 1.
- nub_adn_o = all ones; slv_ackcyn=1.
- mem_valid_o=0, mem_write_o=0, mem_addr_o/wdata/wstrb = 0; state IDLE, counter 0.

Latency, with START sampled at edge E0:
- Read: mem_valid_o is high from E0. Ready sampled at edge Ek puts ACK in the cycle after Ek. Minimum ACK is 2 cycles after START.
- Write: ACCESS starts one cycle later, so minimum ACK is 3 cycles after START.

Handshake:
- mem_valid_o stays high until the edge at which mem_ready_i is sampled or expiry occurs, then drops.
- A late mem_ready_i is ignored.

Drive rules:
- ACK and AD drive last exactly one cycle.
- All drivers are released in the cycle after ACK.

Reset mid-transaction: the next edge returns to IDLE, drops mem_valid_o, and releases all drivers. No ACK is issued.

## Structure
- Shared package `nubus_pkg`:
  - State enum.
  - TM status constants (TM_COMPLETE, TM_ERROR, TM_TIMEOUT, TM_TRYAGAIN).
  - Slot-space prefix 4'hF.
  - Size encodings.
- Sub-module `nubus_slave_decode`: combinational address match and mode/lane decode. It produces `hit`, `write`, `block`, `wstrb`.
- The state machine, counter and output registers live in the top module.

## Test plan
- Word read, ID=4'h9 (nub_idn=4'h6), addr F9000100, ready one cycle after mem_valid -> mem_addr_o=F9000100, wstrb 1111; one-cycle ACK* with TM*=11 (status 00) and AD*=~DEADBEEF when rdata=DEADBEEF.
- Byte write to F9000003, data 000000A5 -> mem_wstrb_o=1000, mem_wdata_o=000000A5; ACK at START+3; AD never driven.
- Ready withheld, MAX_WAIT=4 -> exactly 4 cycles of mem_valid_o, then ACK with status 11 (TM*=00).
- mem_err_i with ready on a read -> status 01 (TM1*=1, TM0*=0); AD not driven. Block request (a=01, tm0=0) -> status 01 with no mem_valid_o.
- Non-matching address FA000000, and an attention cycle (START*=ACK*=0) -> no mem_valid_o and no drive. Superslot 90000000 responds only with SUPER_EN=1.
- nub_reset asserted mid-ACCESS -> all outputs at reset values after the next edge. A following read completes normally.
